// File: rtl/systolic_array_ctrl_if.sv
// Port bundle between the job sequencer, its operand producer, the systolic array
// and the result consumer. The master view belongs to the controller.
interface systolic_array_ctrl_if #(
  parameter int DATAWIDTH = 16,
  parameter int N_SIZE    = 5
);
  localparam int IDXW = $clog2(N_SIZE);

  logic                            ld_valid;
  logic                            ld_ready;
  logic [N_SIZE*DATAWIDTH-1:0]     ld_a_col;
  logic [N_SIZE*DATAWIDTH-1:0]     ld_b_row;

  logic                            sa_rst_n;
  logic                            sa_valid_in;
  logic [N_SIZE*DATAWIDTH-1:0]     sa_a;
  logic [N_SIZE*DATAWIDTH-1:0]     sa_b;
  logic                            sa_valid_out;
  logic [N_SIZE*2*DATAWIDTH-1:0]   sa_c;

  logic                            res_valid;
  logic                            res_ready;
  logic [N_SIZE*2*DATAWIDTH-1:0]   res_data;
  logic [IDXW-1:0]                 res_row;

  modport master (
    input  ld_valid, ld_a_col, ld_b_row, sa_valid_out, sa_c, res_ready,
    output ld_ready, sa_rst_n, sa_valid_in, sa_a, sa_b, res_valid, res_data, res_row
  );

  modport slave (
    output ld_valid, ld_a_col, ld_b_row, sa_valid_out, sa_c, res_ready,
    input  ld_ready, sa_rst_n, sa_valid_in, sa_a, sa_b, res_valid, res_data, res_row
  );
endinterface

// File: rtl/systolic_array_ctrl.sv
// Job sequencer for an N x N systolic array: buffer operands, clear the array,
// feed it, capture its result rows and replay them over a valid/ready port.
module systolic_array_ctrl #(
  parameter int DATAWIDTH = 16,
  parameter int N_SIZE    = 5,
  parameter int TIMEOUT   = 3 * N_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  systolic_array_ctrl_if.master bus,
  output logic                  busy,
  output logic                  err
);
  localparam int OW = N_SIZE * DATAWIDTH;
  localparam int RW = N_SIZE * 2 * DATAWIDTH;
  localparam int CW = $clog2(N_SIZE);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N_SIZE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_ONE   = TW'(1);

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_CLEAR,
    ST_FEED,
    ST_WAIT,
    ST_CAPTURE,
    ST_DRAIN
  } state_t;

  state_t state_reg, state_next;

  logic [OW-1:0] op_a_mem [N_SIZE];
  logic [OW-1:0] op_b_mem [N_SIZE];
  logic [RW-1:0] res_mem  [N_SIZE];

  logic [CW-1:0] beat_cnt_reg, beat_cnt_next;
  logic [CW-1:0] row_cnt_reg, row_cnt_next;
  logic [TW-1:0] to_cnt_reg, to_cnt_next;
  logic          err_reg, err_next;

  logic          ld_ready_reg;
  logic          sa_rst_n_reg;
  logic          sa_valid_in_reg;
  logic [OW-1:0] sa_a_reg;
  logic [OW-1:0] sa_b_reg;
  logic          res_valid_reg;
  logic [RW-1:0] res_data_reg;
  logic [CW-1:0] res_row_reg;
  logic          busy_reg;

  logic          ld_we;
  logic          cap_we;
  logic [CW-1:0] cap_addr;
  logic [CW-1:0] op_rd_addr;
  logic [CW-1:0] res_rd_addr;

  // Read addresses look one entry ahead so the registered read lands on the
  // cycle in which the entry must be presented.
  always_comb begin
    state_next    = state_reg;
    beat_cnt_next = beat_cnt_reg;
    row_cnt_next  = row_cnt_reg;
    to_cnt_next   = to_cnt_reg;
    err_next      = err_reg;
    ld_we         = 1'b0;
    cap_we        = 1'b0;
    cap_addr      = row_cnt_reg;
    op_rd_addr    = '0;
    res_rd_addr   = '0;

    case (state_reg)
      ST_LOAD: begin
        if (bus.ld_valid && ld_ready_reg) begin
          ld_we    = 1'b1;
          err_next = 1'b0;
          if (beat_cnt_reg == CNT_LAST) begin
            beat_cnt_next = '0;
            state_next    = ST_CLEAR;
          end else begin
            beat_cnt_next = beat_cnt_reg + CNT_ONE;
          end
        end
      end

      ST_CLEAR: begin
        beat_cnt_next = '0;
        op_rd_addr    = '0;
        state_next    = ST_FEED;
      end

      ST_FEED: begin
        if (beat_cnt_reg == CNT_LAST) begin
          beat_cnt_next = '0;
          to_cnt_next   = '0;
          state_next    = ST_WAIT;
        end else begin
          beat_cnt_next = beat_cnt_reg + CNT_ONE;
          op_rd_addr    = beat_cnt_reg + CNT_ONE;
        end
      end

      ST_WAIT: begin
        if (bus.sa_valid_out) begin
          cap_we       = 1'b1;
          cap_addr     = '0;
          row_cnt_next = CNT_ONE;
          to_cnt_next  = '0;
          state_next   = ST_CAPTURE;
        end else if (to_cnt_reg == TO_LAST) begin
          err_next    = 1'b1;
          to_cnt_next = '0;
          state_next  = ST_LOAD;
        end else begin
          to_cnt_next = to_cnt_reg + TO_ONE;
        end
      end

      ST_CAPTURE: begin
        if (bus.sa_valid_out) begin
          cap_we = 1'b1;
          if (row_cnt_reg == CNT_LAST) begin
            row_cnt_next = '0;
            state_next   = ST_DRAIN;
          end else begin
            row_cnt_next = row_cnt_reg + CNT_ONE;
          end
        end else begin
          // A gap in the row stream means the job is corrupt; drop it.
          err_next     = 1'b1;
          row_cnt_next = '0;
          state_next   = ST_LOAD;
        end
      end

      ST_DRAIN: begin
        res_rd_addr = row_cnt_reg;
        if (bus.res_ready) begin
          if (row_cnt_reg == CNT_LAST) begin
            row_cnt_next = '0;
            state_next   = ST_LOAD;
          end else begin
            row_cnt_next = row_cnt_reg + CNT_ONE;
            res_rd_addr  = row_cnt_reg + CNT_ONE;
          end
        end
      end

      default: begin
        state_next = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (ld_we) begin
      op_a_mem[beat_cnt_reg] <= bus.ld_a_col;
      op_b_mem[beat_cnt_reg] <= bus.ld_b_row;
    end
    if (cap_we) begin
      res_mem[cap_addr] <= bus.sa_c;
    end
  end

  // Every output is a register decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_LOAD;
      beat_cnt_reg    <= '0;
      row_cnt_reg     <= '0;
      to_cnt_reg      <= '0;
      err_reg         <= 1'b0;
      ld_ready_reg    <= 1'b0;
      sa_rst_n_reg    <= 1'b0;
      sa_valid_in_reg <= 1'b0;
      sa_a_reg        <= '0;
      sa_b_reg        <= '0;
      res_valid_reg   <= 1'b0;
      res_data_reg    <= '0;
      res_row_reg     <= '0;
      busy_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      beat_cnt_reg    <= beat_cnt_next;
      row_cnt_reg     <= row_cnt_next;
      to_cnt_reg      <= to_cnt_next;
      err_reg         <= err_next;
      ld_ready_reg    <= (state_next == ST_LOAD);
      sa_rst_n_reg    <= (state_next != ST_CLEAR);
      sa_valid_in_reg <= (state_next == ST_FEED);
      sa_a_reg        <= (state_next == ST_FEED) ? op_a_mem[op_rd_addr] : '0;
      sa_b_reg        <= (state_next == ST_FEED) ? op_b_mem[op_rd_addr] : '0;
      res_valid_reg   <= (state_next == ST_DRAIN);
      res_data_reg    <= (state_next == ST_DRAIN) ? res_mem[res_rd_addr] : '0;
      res_row_reg     <= (state_next == ST_DRAIN) ? res_rd_addr : '0;
      busy_reg        <= (state_next != ST_LOAD);
    end
  end

  assign bus.ld_ready    = ld_ready_reg;
  assign bus.sa_rst_n    = sa_rst_n_reg;
  assign bus.sa_valid_in = sa_valid_in_reg;
  assign bus.sa_a        = sa_a_reg;
  assign bus.sa_b        = sa_b_reg;
  assign bus.res_valid   = res_valid_reg;
  assign bus.res_data    = res_data_reg;
  assign bus.res_row     = res_row_reg;
  assign busy            = busy_reg;
  assign err             = err_reg;
endmodule
